accelbrot_com_mult_feed: RTL and testbench
==========================================

Name: accelbrot_com_mult_feed

Overview:
Operand sequencer directly upstream of the multi-word × half-word multiplier stage.
- Accepts one multi-word operand pair A, B (NWORDS words each, LSW first) and buffers it.
- Replays A once per B half-word (2*NWORDS passes), driving the multiplier's a/b/ab_start/ab_valid stream.
- Tags each pass with its half-word index so the downstream accumulator can apply the HWIDTH*pass shift.

Parameters:
NWORDS, 8, words per operand block
WWIDTH, 34, word width; must be even (HWIDTH = WWIDTH/2)

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
in_a  in  WWIDTH  operand A word, LSW first
in_b  in  WWIDTH  operand B word, same index as in_a
in_start  in  1  marks word 0 of an input block
in_valid  in  1  input word valid
in_ready  out  1  high only in IDLE/LOAD; word accepted when in_valid & in_ready
a  out  WWIDTH  A word to multiplier
b  out  WWIDTH/2  B half-word for current pass; held constant for the whole pass
ab_start  out  1  first word of a pass
ab_valid  out  1  a/b valid
pass_idx  out  $clog2(2*NWORDS)  half-word index of current pass (0 = B[HWIDTH-1:0] of word 0)
pass_last  out  1  high on every word of the final emitted pass
done  out  1  one-cycle pulse after the final word of the final pass

Behaviour:
- Reset values:
  - All outputs 0, except in_ready = 1.
  - State IDLE; word counter wcnt and pass counter pcnt = 0.
  - Reset mid-LOAD or mid-RUN discards the block; no done pulse.
- States and transitions:
  - IDLE: wait for in_valid & in_start. Store word 0 into A[0]/B[0], wcnt = 1, go to LOAD. in_valid without in_start is dropped.
  - LOAD: each accepted word is stored at index wcnt and wcnt increments.
    - in_start during LOAD restarts the block: the word is stored at index 0 and wcnt = 1.
    - When word NWORDS-1 is accepted: in_ready drops in the next cycle, state becomes RUN, pcnt = 0, wcnt = 0.
    - NWORDS = 1: word 0 is also the last word.
  - RUN: in_ready = 0. One word emitted per cycle with no bubbles, including across pass boundaries.
    - Per cycle: a = A[wcnt], b = half-word pcnt of B, where B[w] holds halves 2w (low) and 2w+1 (high).
    - ab_start = (wcnt == 0). ab_valid = 1.
    - wcnt wraps at NWORDS-1 and pcnt then increments.
    - After the last word of the last pass: go to DONE.
  - DONE: done = 1 for one cycle, then IDLE with in_ready = 1.
- Outputs are registered:
  - If the last input word is accepted on the edge at cycle T, the first ab_valid appears in cycle T+1.
  - Total RUN duration is 2*NWORDS*NWORDS cycles.
- No downstream backpressure; the multiplier always accepts.
- pass_idx, pass_last and b are stable for all NWORDS words of a pass.
- Buffers: 2*NWORDS*WWIDTH flops, written only in IDLE/LOAD.

Optional Feature:
Macro: ACCELBROT_MULT_FEED_SKIPZERO_EN
- Defined:
  - A pass whose B half-word is zero is not emitted; pcnt advances to the next nonzero half-word with no idle cycle.
  - pass_idx still reports the true half-word index. pass_last marks the last nonzero pass.
  - If B is all zero, RUN emits nothing and done pulses in the cycle after load completes.
  - Needs a 2*NWORDS-bit nonzero mask, computed as words are loaded, plus a priority "next set bit" search.
- Undefined: all 2*NWORDS passes are always emitted; no mask logic is present.

Decomposition:
- Package accelbrot_com_pkg:
  - HWIDTH derivation function.
  - State enum {IDLE, LOAD, RUN, DONE}.
  - Counter width localparams.
- Sub-module accelbrot_com_mult_feed_buf: dual-array operand store, with write port (index, data) and combinational read of A[wcnt] and B half-word[pcnt].

Test Plan:
- Nominal (NWORDS=2, WWIDTH=34): A = {0x1, 0x2}, B = {0x3_0001_0002 pattern}.
  - Required: 4 passes × 2 words, contiguous ab_valid for 8 cycles, ab_start on cycles 1, 3, 5, 7.
  - b sequence = halves of B in order; pass_idx 0..3; pass_last on the final 2 words; done once after them.
- Latency: last input word accepted at T → ab_valid at T+1. in_ready = 0 from T+1 until the cycle after done.
- Restart: in_start reasserted on the 2nd word of LOAD → that word becomes A[0]. The block completes with the new data only.
- Reset mid-RUN (cycle 3 of 8):
  - Outputs 0 and in_ready = 1 on the cycle after rstn low; no done pulse.
  - A new block afterwards runs normally.
- Skip-zero (macro defined), B halves {5, 0, 0, 7}:
  - Only pass_idx 0 and 3 are emitted, back-to-back; pass_last on pass 3.
  - B = 0: no ab_valid, done at T+1.
- Idle robustness: in_valid without in_start in IDLE → ignored. Stray valid during RUN → not accepted; buffer unchanged.

Source files
------------

// File: rtl/accelbrot_com_mult_feed_pkg.sv
// Shared types and width helpers for the multiplier operand feed.
// Module parameters default to the package values below.
package accelbrot_com_pkg;

  localparam int NWORDS_DEF = 8;
  localparam int WWIDTH_DEF = 34;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } feed_state_e;

  // Half-word width; operand words are always split into two equal halves.
  function automatic int hwidth(input int wwidth);
    return wwidth / 2;
  endfunction

  // Word counter width, kept at least one bit wide for single-word blocks.
  function automatic int wcnt_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

  // Pass counter width, covering 2*NWORDS half-word passes.
  function automatic int pcnt_width(input int nwords);
    return $clog2(2 * nwords);
  endfunction

endpackage

// File: rtl/accelbrot_com_mult_feed_if.sv
// Operand-feed interface: block input stream in, multiplier word stream out.
// The slave modport is the feed block; the master modport is its environment.
interface accelbrot_com_mult_feed_if
  import accelbrot_com_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEF,
  parameter int WWIDTH = WWIDTH_DEF
) ();

  localparam int HW = hwidth(WWIDTH);
  localparam int PW = pcnt_width(NWORDS);

  logic [WWIDTH-1:0] in_a;
  logic [WWIDTH-1:0] in_b;
  logic              in_start;
  logic              in_valid;
  logic              in_ready;
  logic [WWIDTH-1:0] a;
  logic [HW-1:0]     b;
  logic              ab_start;
  logic              ab_valid;
  logic [PW-1:0]     pass_idx;
  logic              pass_last;
  logic              done;

  modport master (
    output in_a, in_b, in_start, in_valid,
    input  in_ready, a, b, ab_start, ab_valid, pass_idx, pass_last, done
  );

  modport slave (
    input  in_a, in_b, in_start, in_valid,
    output in_ready, a, b, ab_start, ab_valid, pass_idx, pass_last, done
  );

endinterface

// File: rtl/accelbrot_com_mult_feed_buf.sv
// Dual operand store: one write port per block word, combinational reads of
// A[word] and the selected B half-word (pass p uses word p/2, half p%2).
module accelbrot_com_mult_feed_buf
  import accelbrot_com_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEF,
  parameter int WWIDTH = WWIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [wcnt_width(NWORDS)-1:0] widx,
  input  logic [WWIDTH-1:0]             wa,
  input  logic [WWIDTH-1:0]             wb,
  input  logic [wcnt_width(NWORDS)-1:0] ridx,
  input  logic [pcnt_width(NWORDS)-1:0] rpass,
  output logic [WWIDTH-1:0]             ra,
  output logic [hwidth(WWIDTH)-1:0]     rb
);

  localparam int HW  = hwidth(WWIDTH);
  localparam int WCW = wcnt_width(NWORDS);

  logic [WWIDTH-1:0] a_mem [NWORDS];
  logic [WWIDTH-1:0] b_mem [NWORDS];
  logic [WCW-1:0]    b_word;
  logic [WWIDTH-1:0] b_sel;

  // NOTE: operand storage has no reset; every word is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (we) begin
      a_mem[widx] <= wa;
      b_mem[widx] <= wb;
    end
  end

  assign b_word = WCW'(rpass >> 1);
  assign b_sel  = b_mem[b_word];
  assign ra     = a_mem[ridx];
  assign rb     = rpass[0] ? b_sel[WWIDTH-1:HW] : b_sel[HW-1:0];

endmodule

// File: rtl/accelbrot_com_mult_feed.sv
// Operand sequencer: buffers one A/B block, then replays A once per B half-word.
// Optional ACCELBROT_MULT_FEED_SKIPZERO_EN skips passes whose B half-word is zero.
module accelbrot_com_mult_feed
  import accelbrot_com_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEF,
  parameter int WWIDTH = WWIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rstn,
  accelbrot_com_mult_feed_if.slave     bus
);

  localparam int HW  = hwidth(WWIDTH);
  localparam int WCW = wcnt_width(NWORDS);
  localparam int PW  = pcnt_width(NWORDS);
  localparam int NP  = 2 * NWORDS;
  localparam logic [WCW-1:0] W_LAST = WCW'(NWORDS - 1);
  localparam logic [PW-1:0]  P_LAST = PW'(NP - 1);

  feed_state_e       state;
  logic [WCW-1:0]    wcnt;
  logic [WCW-1:0]    widx;
  logic [PW-1:0]     pcnt;
  logic              in_ready_q;
  logic              ab_valid_q;
  logic              ab_start_q;
  logic              pass_last_q;
  logic              done_q;
  logic              acc;
  logic              last_word;
  logic [WWIDTH-1:0] rd_a;
  logic [HW-1:0]     rd_b;

  // First pass of a new block and the pass following the current one.
  logic [PW-1:0]     first_pass;
  logic              first_last;
  logic              any_pass;
  logic [PW-1:0]     next_pass;
  logic              next_last;

  // A word without in_start is only meaningful mid-load; in IDLE it is dropped.
  assign acc       = bus.in_valid && in_ready_q && (bus.in_start || state == LOAD);
  assign widx      = bus.in_start ? '0 : wcnt;
  assign last_word = (widx == W_LAST);

`ifdef ACCELBROT_MULT_FEED_SKIPZERO_EN
  localparam int PW1 = PW + 1;

  logic [NP-1:0] nz;
  logic [NP-1:0] nz_next;
  logic [PW:0]   f0, f1, n0, n1;

  // Lowest set bit of m at or above 'from'; MSB of the result flags a hit.
  function automatic logic [PW:0] find_set(input logic [NP-1:0] m, input logic [PW:0] from);
    find_set = '0;
    for (int i = NP - 1; i >= 0; i--) begin
      if (m[i] && (PW1'(i) >= from)) find_set = {1'b1, PW'(i)};
    end
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    nz_next = nz;
    for (int i = 0; i < NWORDS; i++) begin
      if (acc && widx == WCW'(i)) begin
        nz_next[2*i]   = |bus.in_b[HW-1:0];
        nz_next[2*i+1] = |bus.in_b[WWIDTH-1:HW];
      end
    end
  end

  always_comb begin
    f0         = find_set(nz_next, '0);
    f1         = find_set(nz_next, {1'b0, f0[PW-1:0]} + PW1'(1));
    n0         = find_set(nz, {1'b0, pcnt} + PW1'(1));
    n1         = find_set(nz, {1'b0, n0[PW-1:0]} + PW1'(1));
    any_pass   = f0[PW];
    first_pass = f0[PW-1:0];
    first_last = !f1[PW];
    next_pass  = n0[PW-1:0];
    next_last  = !n1[PW];
  end

  always_ff @(posedge clk) begin
    if (!rstn) nz <= '0;
    else       nz <= nz_next;
  end
`else
  always_comb begin
    any_pass   = 1'b1;
    first_pass = '0;
    first_last = 1'b0;
    next_pass  = pcnt + PW'(1);
    next_last  = (next_pass == P_LAST);
  end
`endif

  // NOTE: all state and output flags update with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      wcnt        <= '0;
      pcnt        <= '0;
      in_ready_q  <= 1'b1;
      ab_valid_q  <= 1'b0;
      ab_start_q  <= 1'b0;
      pass_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE, LOAD: begin
          if (acc) begin
            if (last_word) begin
              in_ready_q <= 1'b0;
              wcnt       <= '0;
              if (any_pass) begin
                state       <= RUN;
                pcnt        <= first_pass;
                ab_valid_q  <= 1'b1;
                ab_start_q  <= 1'b1;
                pass_last_q <= first_last;
              end else begin
                state  <= DONE;
                pcnt   <= '0;
                done_q <= 1'b1;
              end
            end else begin
              state <= LOAD;
              wcnt  <= widx + WCW'(1);
            end
          end
        end
        RUN: begin
          if (wcnt == W_LAST) begin
            wcnt <= '0;
            if (pass_last_q) begin
              state       <= DONE;
              pcnt        <= '0;
              ab_valid_q  <= 1'b0;
              ab_start_q  <= 1'b0;
              pass_last_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              pcnt        <= next_pass;
              ab_start_q  <= 1'b1;
              pass_last_q <= next_last;
            end
          end else begin
            wcnt       <= wcnt + WCW'(1);
            ab_start_q <= 1'b0;
          end
        end
        DONE: begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  accelbrot_com_mult_feed_buf #(
    .NWORDS (NWORDS),
    .WWIDTH (WWIDTH)
  ) u_buf (
    .clk   (clk),
    .we    (acc),
    .widx  (widx),
    .wa    (bus.in_a),
    .wb    (bus.in_b),
    .ridx  (wcnt),
    .rpass (pcnt),
    .ra    (rd_a),
    .rb    (rd_b)
  );

  // Data outputs are forced to zero outside RUN so idle and reset read as 0.
  assign bus.in_ready  = in_ready_q;
  assign bus.a         = ab_valid_q ? rd_a : '0;
  assign bus.b         = ab_valid_q ? rd_b : '0;
  assign bus.ab_start  = ab_start_q;
  assign bus.ab_valid  = ab_valid_q;
  assign bus.pass_idx  = pcnt;
  assign bus.pass_last = pass_last_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_accelbrot_com_mult_feed.sv
// Scoreboard bench for accelbrot_com_mult_feed (NWORDS=2, WWIDTH=34); expected
// multiplier words are queued at stimulus time and popped as ab_valid words appear.
module tb_accelbrot_com_mult_feed;

  localparam int N  = 2;
  localparam int W  = 34;
  localparam int HW = 17;
  localparam int PW = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  accelbrot_com_mult_feed_if #(.NWORDS(N), .WWIDTH(W)) bus ();

  accelbrot_com_mult_feed #(.NWORDS(N), .WWIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  bit          mon_en   = 1'b0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] pack_word(input logic [W-1:0] a, input logic [HW-1:0] b,
                                            input logic s, input logic l, input logic [PW-1:0] p);
    return {9'd0, a, b, s, l, p};
  endfunction

  // Every output in one word; after reset only in_ready (bit 0) is set.
  function automatic logic [63:0] snap();
    return {6'd0, bus.a, bus.b, bus.ab_start, bus.ab_valid, bus.pass_last,
            bus.pass_idx, bus.done, bus.in_ready};
  endfunction

  // Reference model: expected multiplier words for one block.
  task automatic push_model(input logic [W-1:0] a0, input logic [W-1:0] a1,
                            input logic [W-1:0] b0, input logic [W-1:0] b1, output int n);
    logic [W-1:0]  av[N];
    logic [W-1:0]  bv[N];
    logic [HW-1:0] h[2*N];
    int            pl[$];
    av[0] = a0; av[1] = a1; bv[0] = b0; bv[1] = b1;
    for (int p = 0; p < 2 * N; p++) begin
      h[p] = (p % 2 == 1) ? bv[p/2][W-1:HW] : bv[p/2][HW-1:0];
`ifdef ACCELBROT_MULT_FEED_SKIPZERO_EN
      if (h[p] != '0) pl.push_back(p);
`else
      pl.push_back(p);
`endif
    end
    n = 0;
    for (int k = 0; k < pl.size(); k++) begin
      for (int w = 0; w < N; w++) begin
        exp_q.push_back(pack_word(av[w], h[pl[k]], w == 0, k == pl.size() - 1, PW'(pl[k])));
        n++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (mon_en && bus.ab_valid) begin
      if (exp_q.size() == 0) check("unexpected_word", {63'd0, bus.ab_valid}, 64'd0);
      else check("word", pack_word(bus.a, bus.b, bus.ab_start, bus.pass_last, bus.pass_idx),
                 exp_q.pop_front());
    end
  end

  task automatic drive_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_start = s;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Loads one block, then follows the run to done; optionally drives stray words meanwhile.
  task automatic run_block(input logic [W-1:0] a0, input logic [W-1:0] a1,
                           input logic [W-1:0] b0, input logic [W-1:0] b1, input bit stray);
    int n;
    int cyc;
    int d0;
    bit got;
    push_model(a0, a1, b0, b1, n);
    d0 = done_cnt;
    drive_word(a0, b0, 1'b1);
    drive_word(a1, b1, 1'b0);
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    @(negedge clk);
    #1;
    check("first_valid", bus.ab_valid, n != 0);
    check("first_done", bus.done, n == 0);
    cyc = 1;
    got = bus.done;
    while (!got && cyc < 100) begin
      check("in_ready_run", bus.in_ready, 1'b0);
      if (stray) begin
        bus.in_valid = 1'b1;
        bus.in_start = 1'b1;
        bus.in_a     = W'({$urandom(), $urandom()});
        bus.in_b     = W'({$urandom(), $urandom()});
      end
      @(negedge clk);
      #1;
      cyc++;
      got = bus.done;
    end
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    if (!got) check("done_timeout", bus.done, 1'b1);
    check("run_len", cyc, n + 1);
    check("done_once", done_cnt - d0, 1);
    check("drained", exp_q.size(), 0);
    @(negedge clk);
    #1;
    check("ready_after_done", {bus.in_ready, bus.done}, 2'b10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_start = 1'b0;
    bus.in_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", snap(), 64'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    #1;
    check("post_reset", snap(), 64'd1);
    mon_en = 1'b1;

    // A word without in_start in IDLE must not start a block.
    drive_word(34'h5, 34'h6, 1'b0);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("idle_ignore", snap(), 64'd1);

    run_block(34'h1, 34'h2, 34'h3_0001_0002, 34'h1_2345_6789, 1'b0);

    // Restart: a second in_start word becomes A[0]; the 0xAA word is discarded.
    drive_word(34'hAA, 34'hBB, 1'b1);
    run_block(34'h11, 34'h22, 34'h0_00FF_0F0F, 34'h3_FFFF_FFFF, 1'b0);

    run_block(34'h7, 34'h9, 34'h2_AAAA_5555, 34'h0_0000_1234, 1'b1);

    // Reset in the third RUN cycle discards the block with no done pulse.
    mon_en = 1'b0;
    d0 = done_cnt;
    drive_word(34'h1_0000_0001, 34'h2, 1'b1);
    drive_word(34'h2_0000_0002, 34'h3, 1'b0);
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("run_before_reset", bus.ab_valid, 1'b1);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_run", snap(), 64'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("no_done_after_reset", done_cnt - d0, 0);
    mon_en = 1'b1;
    run_block(34'h3_0000_0000, 34'h1_5555_5555, 34'h1_0000_0001, 34'h2_0000_0003, 1'b0);

    // Sparse and all-zero B; the model decides which passes are expected.
    run_block(34'h3, 34'h4, 34'd5, 34'd7 << 17, 1'b0);
    run_block(34'h3, 34'h4, 34'd0, 34'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
